bsg_credit_sender_small: RTL and testbench

- Upstream partner of a credit-on-input receive FIFO.
- Accepts a valid/ready input stream, buffers it in a 2-entry FIFO, and forwards words over a registered valid/credit link.
- Tracks the receiver's free slots with a credit counter. Never sends more words than the receiver can hold.
- Flags protocol violations: a credit returned while all credits are already held.

---
 rtl/bsg_credit_sender_small.sv | 92 +++++++++
 tb/tb_bsg_credit_sender_small.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_credit_sender_small.sv
// rtl/bsg_credit_sender_small.sv - credit-based sender with a 2-entry input buffer
module bsg_credit_sender_small #(
    parameter int width_p         = -1,
    parameter int credit_max_p    = -1,
    localparam int credit_width_lp = (credit_max_p < 1) ? 1 : $clog2(credit_max_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       v_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       credit_i,
    output logic [credit_width_lp-1:0] credit_count_o,
    output logic                       error_o
);

    localparam logic [credit_width_lp-1:0] credit_max_lp = credit_width_lp'(credit_max_p);

    logic [width_p-1:0]         buf_r [2];
    logic                       wr_ptr_r;
    logic                       rd_ptr_r;
    logic [1:0]                 occ_r;
    logic [credit_width_lp-1:0] count_r;
    logic                       v_r;
    logic                       error_r;
    logic [width_p-1:0]         data_r;

    logic enq;
    logic send;

    // ready and the send decision look only at registered state, never at
    // credit_i, so a returned credit is usable one cycle after it arrives.
    assign ready_o = (occ_r != 2'd2);
    assign enq     = v_i & ready_o;
    assign send    = (occ_r != 2'd0) & (count_r != '0);

    // Buffer pointers, occupancy and the output-valid pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
            v_r      <= 1'b0;
        end else begin
            if (enq) wr_ptr_r <= ~wr_ptr_r;
            if (send) rd_ptr_r <= ~rd_ptr_r;
            if (enq & ~send)
                occ_r <= occ_r + 2'd1;
            else if (send & ~enq)
                occ_r <= occ_r - 2'd1;
            v_r <= send;
        end
    end

    // Buffer storage and output data register; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (enq) buf_r[wr_ptr_r] <= data_i;
        if (send) data_r <= buf_r[rd_ptr_r];
    end

    // Credit counter with saturation at the maximum and a sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= credit_max_lp;
            error_r <= 1'b0;
        end else begin
            if (send & ~credit_i) begin
                count_r <= count_r - 1'b1;
            end else if (credit_i & ~send) begin
                if (count_r == credit_max_lp)
                    error_r <= 1'b1;
                else
                    count_r <= count_r + 1'b1;
            end
        end
    end

    // Parameter sanity, checked while the block is held in reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            assert (credit_max_p >= 1 && width_p >= 1);
        end
    end

    assign v_o            = v_r;
    assign data_o         = data_r;
    assign credit_count_o = count_r;
    assign error_o        = error_r;

endmodule

// File: tb/tb_bsg_credit_sender_small.sv
// tb/tb_bsg_credit_sender_small.sv - directed and randomized bench for bsg_credit_sender_small
module tb_bsg_credit_sender_small;

    localparam int W    = 8;
    localparam int CMAX = 4;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [W-1:0]  data_i = '0;
    logic          v_i = 1'b0;
    logic          ready_o;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          credit_i = 1'b0;
    logic [CW-1:0] credit_count_o;
    logic          error_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bsg_credit_sender_small #(.width_p(W), .credit_max_p(CMAX)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .data_i         (data_i),
        .v_i            (v_i),
        .ready_o        (ready_o),
        .v_o            (v_o),
        .data_o         (data_o),
        .credit_i       (credit_i),
        .credit_count_o (credit_count_o),
        .error_o        (error_o)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic       cr;
        logic       rdy;
        logic       vo;
        logic [7:0] dout;
        logic [2:0] cnt;
        logic       err;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic rst, input logic v, input logic [7:0] d,
                                input logic cr, input logic rdy, input logic vo,
                                input logic [7:0] dout, input int cnt, input logic err);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.cr = cr;
        r.rdy = rdy; r.vo = vo; r.dout = dout; r.cnt = 3'(cnt); r.err = err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic c);
        reset_i  = r;
        v_i      = v;
        data_i   = d;
        credit_i = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string p, input logic rdy, input logic vo,
                             input logic [7:0] dout, input int cnt, input logic err);
        chk({p, ".ready"}, 32'(ready_o), 32'(rdy));
        chk({p, ".v_o"}, 32'(v_o), 32'(vo));
        if (vo) chk({p, ".data_o"}, 32'(data_o), 32'(dout));
        chk({p, ".count"}, 32'(credit_count_o), 32'(cnt));
        chk({p, ".error"}, 32'(error_o), 32'(err));
    endtask

    // Bounds the whole run in case the DUT stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] sb [$];
        logic [7:0] rx [$];
        logic [7:0] expv;
        logic       acc;
        logic       done;

        tbl[0]  = mk(1, 0, 8'h00, 0,  1, 0, 8'h00, 4, 0);
        tbl[1]  = mk(0, 1, 8'hA0, 0,  1, 0, 8'h00, 4, 0);
        tbl[2]  = mk(0, 1, 8'hA1, 0,  1, 1, 8'hA0, 3, 0);
        tbl[3]  = mk(0, 1, 8'hA2, 0,  1, 1, 8'hA1, 2, 0);
        tbl[4]  = mk(0, 1, 8'hA3, 0,  1, 1, 8'hA2, 1, 0);
        tbl[5]  = mk(0, 1, 8'hA4, 0,  1, 1, 8'hA3, 0, 0);
        tbl[6]  = mk(0, 1, 8'hA5, 0,  0, 0, 8'h00, 0, 0);
        tbl[7]  = mk(0, 1, 8'hEE, 1,  0, 0, 8'h00, 1, 0);
        tbl[8]  = mk(0, 1, 8'hEE, 0,  1, 1, 8'hA4, 0, 0);
        tbl[9]  = mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 1, 0);
        tbl[10] = mk(0, 0, 8'h00, 0,  1, 1, 8'hA5, 0, 0);
        tbl[11] = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0);
        tbl[12] = mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 1, 0);
        tbl[13] = mk(0, 1, 8'hB0, 1,  1, 0, 8'h00, 2, 0);
        tbl[14] = mk(0, 1, 8'hB1, 1,  1, 1, 8'hB0, 2, 0);
        tbl[15] = mk(0, 1, 8'hB2, 1,  1, 1, 8'hB1, 2, 0);
        tbl[16] = mk(0, 1, 8'hB3, 1,  1, 1, 8'hB2, 2, 0);
        tbl[17] = mk(0, 0, 8'h00, 0,  1, 1, 8'hB3, 1, 0);
        tbl[18] = mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 2, 0);
        tbl[19] = mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 3, 0);
        tbl[20] = mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 4, 0);
        tbl[21] = mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 4, 1);
        tbl[22] = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 4, 1);

        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].cr);
            check_out($sformatf("row%0d", i), tbl[i].rdy, tbl[i].vo, tbl[i].dout,
                      int'(tbl[i].cnt), tbl[i].err);
        end

        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'h00, 0);
            chk($sformatf("sticky%0d.error", i), 32'(error_o), 32'd1);
            chk($sformatf("sticky%0d.count", i), 32'(credit_count_o), 32'd4);
        end
        step(1, 0, 8'h00, 0);
        check_out("ovf_reset", 1, 0, 8'h00, 4, 0);

        step(0, 1, 8'hC0, 0);
        check_out("max_enq", 1, 0, 8'h00, 4, 0);
        step(0, 0, 8'h00, 1);
        check_out("max_send_credit", 1, 1, 8'hC0, 4, 0);

        for (int i = 0; i < 6; i++) step(0, 1, 8'(8'hD0 + i), 0);
        check_out("mid_full", 0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1);
        check_out("mid_cnt1", 0, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 1);
        check_out("mid_reset", 1, 0, 8'h00, 4, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'h00, 0);
            check_out($sformatf("post_reset%0d", i), 1, 0, 8'h00, 4, 0);
        end

        reset_i = 1'b0;
        v_i = 1'b0;
        credit_i = 1'b0;
        acc = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (v_o) begin
                rx.push_back(data_o);
                if (sb.size() == 0) begin
                    chk("rand.unexpected_word", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    expv = sb.pop_front();
                    chk("rand.data", 32'(data_o), 32'(expv));
                end
                chk("rand.rx_overflow", 32'(rx.size() > CMAX), 32'd0);
            end
            if (error_o) chk("rand.error", 32'(error_o), 32'd0);
            if (cyc >= 450 && sb.size() == 0 && rx.size() == 0 && !v_i) begin
                done = 1'b1;
                break;
            end
            credit_i = 1'b0;
            if (rx.size() > 0 && $urandom_range(2) == 0) begin
                void'(rx.pop_front());
                credit_i = 1'b1;
            end
            if (!(v_i && !acc)) begin
                if (cyc < 400) begin
                    v_i = 1'($urandom_range(1));
                    data_i = 8'($urandom);
                end else begin
                    v_i = 1'b0;
                end
            end
            acc = v_i && ready_o;
            if (acc) sb.push_back(data_i);
            @(posedge clk);
            @(negedge clk);
        end
        credit_i = 1'b0;
        v_i = 1'b0;
        chk("rand.drained", 32'(done), 32'd1);
        chk("rand.final_count", 32'(credit_count_o), 32'd4);
        chk("rand.final_error", 32'(error_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
